// File: rtl/serial_subtractor32_if.sv
// rtl/serial_subtractor32_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_subtractor32_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, minuend, subtrahend, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, minuend, subtrahend, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor32.sv
// rtl/serial_subtractor32.sv - slice-serial A - B - bin subtractor with borrow, overflow and zero flags
module serial_subtractor32 #(
    parameter int SLICE_W = 8,
    parameter int SLICES  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_subtractor32_if.slave bus
);
    localparam int W  = SLICE_W * SLICES;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            bin_q, bin_d;
    logic            borrow_q, borrow_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic               borrow_in;
    logic [SLICE_W:0]   slice_res;

    // One slice of subtraction per cycle; the extra top bit of slice_res is the slice borrow.
    always_comb begin
        a_slice   = a_q[int'(k_q)*SLICE_W +: SLICE_W];
        b_slice   = b_q[int'(k_q)*SLICE_W +: SLICE_W];
        borrow_in = (k_q == '0) ? bin_q : borrow_q;
        slice_res = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE_W{1'b0}}, borrow_in};
    end

    // Next-state, datapath and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        bin_d       = bin_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.minuend;
                    b_d        = bus.subtrahend;
                    bin_d      = bus.bin;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                diff_d[int'(k_q)*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
                borrow_d = slice_res[SLICE_W];
                if (k_q == K_LAST) begin
                    // Flags are derived from the fully assembled difference of this edge.
                    bout_d      = slice_res[SLICE_W];
                    ovf_d       = (a_q[W-1] != b_q[W-1]) && (diff_d[W-1] != a_q[W-1]);
                    zero_d      = (diff_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation and leaves the block ready in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bin_q       <= bin_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign bus.in_ready  = in_ready_q & rst_n;
    assign bus.out_valid = out_valid_q & rst_n;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor32.sv
// tb/tb_serial_subtractor32.sv - randomized self-checking bench for serial_subtractor32
module tb_serial_subtractor32;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_subtractor32_if #(.W(32)) bus ();

    serial_subtractor32 #(.SLICE_W(8), .SLICES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d, output logic bo, output logic ov, output logic z);
        longint unsigned lhs, rhs;
        lhs = longint'(a);
        rhs = longint'(b) + longint'(bi);
        d   = 32'(lhs - rhs);
        bo  = (lhs < rhs);
        ov  = (a[31] != b[31]) && (d[31] != a[31]);
        z   = (d == 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic bi, input int hold, input bit early_ready);
        logic [31:0] ed;
        logic        eb, eo, ez;
        int          lat;
        model(a, b, bi, ed, eb, eo, ez);
        wait_ready(tag);
        bus.in_valid   = 1'b1;
        bus.minuend    = a;
        bus.subtrahend = b;
        bus.bin        = bi;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Operands and in_valid change after accept; none of it may disturb the result.
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.minuend    = $urandom;
        bus.subtrahend = $urandom;
        bus.bin        = 1'($urandom_range(0, 1));
        bus.out_ready  = early_ready;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_flags"}, {29'd0, bus.bout, bus.ovf, bus.zero}, {29'd0, eb, eo, ez});
        check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                bus.in_valid   = 1'b1;
                bus.minuend    = $urandom;
                bus.subtrahend = $urandom;
                @(posedge clk);
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_diff"}, bus.diff, ed);
                check({tag, "_hold_flags"}, {29'd0, bus.bout, bus.ovf, bus.zero}, {29'd0, eb, eo, ez});
                check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
        end
        // in_valid stays high through the output handshake edge and must not be taken.
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_released"}, {30'd0, bus.out_valid, bus.in_ready}, {30'd0, 1'b0, 1'b1});
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        bus.bin        = 1'b0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        check("rst_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {bus.diff[28:0], bus.bout, bus.ovf, bus.zero}, 32'd0);
        check("rst_diff", bus.diff, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);

        do_op("small",   32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
        do_op("ripple",  32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b1);
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
        do_op("bin_zero", 32'h0000_0100, 32'h0000_00FF, 1'b1, 0, 1'b1);
        do_op("hold3",   32'h1234_5678, 32'h0FED_CBA9, 1'b1, 3, 1'b0);

        // Reset while slice 2 is being computed.
        wait_ready("abort");
        bus.in_valid   = 1'b1;
        bus.minuend    = 32'hDEAD_BEEF;
        bus.subtrahend = 32'h0123_4567;
        bus.bin        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_rst_diff", bus.diff, 32'd0);
        check("abort_rst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
        do_op("after_abort", 32'h0000_0010, 32'h0000_0001, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra + 32'd1;
                2: ra = {1'b1, 31'($urandom)};
                default: ;
            endcase
            do_op("rand", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
